// File: rtl/north_bridge_arbiter.sv
// North-bridge FIFO sharing: round-robin ingress into the transfer FIFO, FSM egress with ack timeout.
// Optional macro CPU_PRIORITY_EN: device 0 pre-empts the round robin whenever it requests.
module north_bridge_arbiter #(
    parameter int DEVICES     = 3,
    parameter int DATA_W      = 16,
    parameter int ID_W        = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DEVICES-1:0]  device_req,
    input  logic [DATA_W-1:0]   data_in,
    output logic [ID_W-1:0]     selector_in,
    output logic [DEVICES-1:0]  device_ack,
    output logic [DATA_W-1:0]   fifo_data,
    output logic                wrreq,
    input  logic                fifo_almost_full,
    input  logic                fifo_empty,
    output logic                rdreq,
    input  logic [DATA_W-1:0]   fifo_q,
    output logic [DATA_W-1:0]   data_out,
    output logic [ID_W-1:0]     selector_out,
    output logic                out_valid,
    input  logic                out_ack,
    output logic [7:0]          drop_cnt
);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, DELIVER} state_t;
    state_t state, state_next;

    logic [ID_W-1:0] rr_ptr, gnt_idx, ptr_next;
    logic [ID_W:0]   cand, gnt_inc;
    logic            gnt_valid, cpu_win;

    // Scan rr_ptr, rr_ptr+1, ... modulo DEVICES for the first requester.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cpu_win   = 1'b0;
        cand      = '0;
        if (!fifo_almost_full) begin
`ifdef CPU_PRIORITY_EN
            if (device_req[0]) begin
                gnt_valid = 1'b1;
                cpu_win   = 1'b1;
            end
`endif
            for (int i = 0; i < DEVICES; i++) begin
                cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
                if (cand >= (ID_W+1)'(DEVICES))
                    cand = cand - (ID_W+1)'(DEVICES);
                if (!gnt_valid && device_req[cand[ID_W-1:0]]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand[ID_W-1:0];
                end
            end
        end
        gnt_inc  = {1'b0, gnt_idx} + 1'b1;
        ptr_next = (gnt_inc >= (ID_W+1)'(DEVICES)) ? '0 : gnt_inc[ID_W-1:0];
    end

    assign selector_in = gnt_valid ? gnt_idx : rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            wrreq      <= 1'b0;
            fifo_data  <= '0;
            device_ack <= '0;
        end else begin
            wrreq      <= gnt_valid;
            device_ack <= gnt_valid ? (DEVICES'(1) << gnt_idx) : '0;
            if (gnt_valid) begin
                fifo_data <= data_in;
                if (!cpu_win)
                    rr_ptr <= ptr_next;
            end
        end
    end

    logic [ID_W-1:0] q_id;
    logic            id_bad, to_hit, drop;
    logic [TO_W-1:0] tcnt;

    assign q_id   = fifo_q[DATA_W-1 -: ID_W];
    assign id_bad = {1'b0, q_id} >= (ID_W+1)'(DEVICES);
    // The word is dropped on the cycle that would push the count to ACK_TIMEOUT,
    // so out_valid stays high for at most ACK_TIMEOUT cycles.
    assign to_hit = (tcnt == TO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        rdreq      = 1'b0;
        out_valid  = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE:    if (!fifo_empty) state_next = FETCH;
            FETCH: begin
                rdreq      = 1'b1;
                state_next = LATCH;
            end
            LATCH: begin
                drop       = id_bad;
                state_next = id_bad ? IDLE : DELIVER;
            end
            DELIVER: begin
                out_valid = 1'b1;
                if (out_ack) begin
                    state_next = IDLE;
                end else if (to_hit) begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out     <= '0;
            selector_out <= '0;
            tcnt         <= '0;
            drop_cnt     <= '0;
        end else begin
            if (state == LATCH) begin
                data_out     <= fifo_q;
                selector_out <= q_id;
                tcnt         <= '0;
            end else if (state == DELIVER && !out_ack && !to_hit) begin
                tcnt <= tcnt + 1'b1;
            end
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_north_bridge_arbiter.sv
// Self-checking bench for north_bridge_arbiter: ingress scoreboard against a round-robin model,
// egress driven from a bench-side FIFO with expected deliveries queued at push time.
`timescale 1ns/1ps
module tb_north_bridge_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  device_req;
    logic [15:0] data_in;
    logic [1:0]  selector_in;
    logic [2:0]  device_ack;
    logic [15:0] fifo_data;
    logic        wrreq;
    logic        fifo_almost_full;
    logic        fifo_empty;
    logic        rdreq;
    logic [15:0] fifo_q = 16'h0;
    logic [15:0] data_out;
    logic [1:0]  selector_out;
    logic        out_valid;
    logic        out_ack;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int tick = 0;
    int model_ptr = 0;
    int pushed = 0;
    int popped = 0;
    logic [15:0] fifo_mem [0:511];
    logic [15:0] exp_out [$];

    typedef struct packed {
        logic        wr;
        logic [2:0]  ack;
        logic [15:0] data;
    } ing_t;
    ing_t ing_q [$];

    north_bridge_arbiter dut (
        .clk(clk), .rst(rst), .device_req(device_req), .data_in(data_in),
        .selector_in(selector_in), .device_ack(device_ack), .fifo_data(fifo_data),
        .wrreq(wrreq), .fifo_almost_full(fifo_almost_full), .fifo_empty(fifo_empty),
        .rdreq(rdreq), .fifo_q(fifo_q), .data_out(data_out), .selector_out(selector_out),
        .out_valid(out_valid), .out_ack(out_ack), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    // Device-side mux: each word carries the selected device in its top bits and a running stamp.
    assign data_in    = {selector_in, tick[13:0]};
    assign fifo_empty = (pushed == popped);

    always @(posedge clk) begin
        if (rdreq && pushed != popped) begin
            fifo_q <= fifo_mem[popped % 512];
            popped <= popped + 1;
        end
    end

    task automatic fifo_push(input logic [15:0] w);
        fifo_mem[pushed % 512] = w;
        pushed = pushed + 1;
        if (w[15:14] != 2'd3) exp_out.push_back(w);
    endtask

    function automatic void predict(input logic [2:0] req, input logic af, input int ptr,
                                    output logic v, output int g);
        v = 1'b0;
        g = 0;
        if (!af) begin
`ifdef CPU_PRIORITY_EN
            if (req[0]) v = 1'b1;
`endif
            for (int i = 0; i < 3; i++) begin
                int c;
                c = (ptr + i) % 3;
                if (!v && req[c]) begin
                    v = 1'b1;
                    g = c;
                end
            end
        end
    endfunction

    // One ingress cycle: compare last cycle's expected capture, then drive and predict this one.
    task automatic ingress_cycle(input logic [2:0] req, input logic af);
        logic v;
        int   g;
        ing_t e;
        @(negedge clk);
        if (ing_q.size() > 0) begin
            e = ing_q.pop_front();
            checks++;
            if (wrreq !== e.wr || device_ack !== e.ack || (e.wr && fifo_data !== e.data)) begin
                errors++;
                $display("FAIL ingress: got wr=%b ack=%b data=%h, expected wr=%b ack=%b data=%h",
                         wrreq, device_ack, fifo_data, e.wr, e.ack, e.data);
            end
        end
        device_req       = req;
        fifo_almost_full = af;
        #1;
        predict(req, af, model_ptr, v, g);
        checks++;
        if (selector_in !== (v ? 2'(g) : 2'(model_ptr))) begin
            errors++;
            $display("FAIL selector_in: got %0d expected %0d", selector_in, v ? g : model_ptr);
        end
        e.wr   = v;
        e.ack  = v ? 3'(1 << g) : 3'b000;
        e.data = {2'(g), tick[13:0]};
        ing_q.push_back(e);
        if (v) begin
`ifdef CPU_PRIORITY_EN
            if (!req[0]) model_ptr = (g + 1) % 3;
`else
            model_ptr = (g + 1) % 3;
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (wrreq !== 0 || device_ack !== 0 || fifo_data !== 0 || rdreq !== 0 || out_valid !== 0 ||
            data_out !== 0 || selector_out !== 0 || drop_cnt !== 0 || selector_in !== 0) begin
            errors++;
            $display("FAIL reset: wr=%b ack=%b fd=%h rd=%b ov=%b do=%h so=%0d dc=%0d si=%0d, expected all 0",
                     wrreq, device_ack, fifo_data, rdreq, out_valid, data_out, selector_out, drop_cnt, selector_in);
        end
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 6; i++) ingress_cycle(3'b111, 1'b0);
        ingress_cycle(3'b101, 1'b0);
        ingress_cycle(3'b101, 1'b0);
        ingress_cycle(3'b010, 1'b0);
        ingress_cycle(3'b000, 1'b0);
    endtask

    task automatic test_almost_full();
        ingress_cycle(3'b110, 1'b0);
        for (int i = 0; i < 3; i++) ingress_cycle(3'b111, 1'b1);
        ingress_cycle(3'b111, 1'b0);
        ingress_cycle(3'b111, 1'b0);
        ingress_cycle(3'b000, 1'b0);
        ingress_cycle(3'b000, 1'b0);
        ing_q.delete();
    endtask

`ifdef CPU_PRIORITY_EN
    task automatic test_cpu_priority();
        for (int i = 0; i < 3; i++) ingress_cycle(3'b111, 1'b0);
        for (int i = 0; i < 4; i++) ingress_cycle(3'b110, 1'b0);
        ingress_cycle(3'b000, 1'b0);
        ingress_cycle(3'b000, 1'b0);
        ing_q.delete();
    endtask
`endif

    task automatic test_deliver();
        logic [15:0] w;
        out_ack = 1'b0;
        @(negedge clk);
        fifo_push(16'h4ABC);
        @(negedge clk);
        checks++;
        if (rdreq !== 1'b1) begin
            errors++;
            $display("FAIL fetch_rdreq: got %b expected 1", rdreq);
        end
        @(negedge clk);
        checks++;
        if (rdreq !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latch_cycle: rdreq=%b out_valid=%b expected 0 0", rdreq, out_valid);
        end
        w = exp_out.pop_front();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || selector_out !== w[15:14] || data_out !== w) begin
                errors++;
                $display("FAIL deliver[%0d]: ov=%b sel=%0d data=%h expected 1 %0d %h",
                         k, out_valid, selector_out, data_out, w[15:14], w);
            end
            if (k == 4) out_ack = 1'b1;
        end
        @(negedge clk);
        out_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_release: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_drop_timeout();
        int vcnt;
        bit done;
        logic [15:0] w;
        out_ack = 1'b0;
        @(negedge clk);
        fifo_push(16'hC000);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || drop_cnt !== ((k == 3) ? 8'd1 : 8'd0)) begin
                errors++;
                $display("FAIL bad_id[%0d]: ov=%b drop_cnt=%0d expected 0 %0d",
                         k, out_valid, drop_cnt, (k == 3) ? 1 : 0);
            end
        end
        fifo_push(16'h0001);
        w = exp_out.pop_front();
        vcnt = 0;
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (out_valid) begin
                if (vcnt == 0) begin
                    checks++;
                    if (data_out !== w || selector_out !== 2'd0) begin
                        errors++;
                        $display("FAIL timeout_word: data=%h sel=%0d expected %h 0", data_out, selector_out, w);
                    end
                end
                vcnt++;
            end else if (vcnt > 0) begin
                done = 1;
            end
        end
        checks++;
        if (!done || vcnt != 255 || drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL timeout: valid_cycles=%0d drop_cnt=%0d ended=%0d expected 255 2 1", vcnt, drop_cnt, done);
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        logic [15:0] w;
        out_ack = 1'b1;
        @(negedge clk);
        fifo_push(16'h0011);
        fifo_push(16'h8022);
        fifo_push(16'hC0FF);
        fifo_push(16'h4033);
        seen = 0;
        for (int k = 0; k < 60 && seen < 3; k++) begin
            @(negedge clk);
            if (out_valid) begin
                w = exp_out.pop_front();
                seen++;
                checks++;
                if (data_out !== w || selector_out !== w[15:14]) begin
                    errors++;
                    $display("FAIL order: data=%h sel=%0d expected %h %0d", data_out, selector_out, w, w[15:14]);
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        out_ack = 1'b0;
        checks++;
        if (seen != 3 || drop_cnt !== 8'd3) begin
            errors++;
            $display("FAIL back_to_back: delivered=%0d drop_cnt=%0d expected 3 3", seen, drop_cnt);
        end
    endtask

    task automatic test_saturation();
        bit stray;
        stray = 0;
        @(negedge clk);
        for (int i = 0; i < 260; i++) fifo_push(16'hC000);
        for (int k = 0; k < 1000 && pushed != popped; k++) begin
            @(negedge clk);
            if (out_valid) stray = 1;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (drop_cnt !== 8'd255 || stray || pushed != popped) begin
            errors++;
            $display("FAIL saturation: drop_cnt=%0d stray_valid=%0d left=%0d expected 255 0 0",
                     drop_cnt, stray, pushed - popped);
        end
    endtask

    task automatic test_reset_mid_deliver();
        bit got;
        logic [15:0] w;
        out_ack = 1'b0;
        @(negedge clk);
        fifo_push(16'h8123);
        w = exp_out.pop_front();
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        checks++;
        if (!got || data_out !== w) begin
            errors++;
            $display("FAIL pre_reset_deliver: out_valid_seen=%0d data=%h expected 1 %h", got, data_out, w);
        end
        device_req = 3'b111;
        @(negedge clk);
        device_req = 3'b000;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (wrreq !== 0 || device_ack !== 0 || fifo_data !== 0 || rdreq !== 0 || out_valid !== 0 ||
            data_out !== 0 || selector_out !== 0 || drop_cnt !== 0 || selector_in !== 0) begin
            errors++;
            $display("FAIL mid_reset: wr=%b ack=%b fd=%h rd=%b ov=%b do=%h so=%0d dc=%0d si=%0d, expected all 0",
                     wrreq, device_ack, fifo_data, rdreq, out_valid, data_out, selector_out, drop_cnt, selector_in);
        end
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 0 || rdreq !== 0 || drop_cnt !== 0) begin
                errors++;
                $display("FAIL post_reset_idle[%0d]: ov=%b rd=%b dc=%0d expected 0 0 0", k, out_valid, rdreq, drop_cnt);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        device_req       = 3'b000;
        fifo_almost_full = 1'b0;
        out_ack          = 1'b0;
        test_reset();
        test_round_robin();
        test_almost_full();
`ifdef CPU_PRIORITY_EN
        test_cpu_priority();
`endif
        test_deliver();
        test_drop_timeout();
        test_back_to_back();
        test_saturation();
        test_reset_mid_deliver();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
